// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline stage register
package pipe_pkg;

  typedef logic [1:0] occ_t;

  localparam int PIPE_DEF_WIDTH = 64;
  localparam logic [PIPE_DEF_WIDTH-1:0] PIPE_NOP = '0;

  function automatic occ_t occ_count(input logic main_v, input logic skid_v);
    return occ_t'({1'b0, main_v}) + occ_t'({1'b0, skid_v});
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid bit plus payload register with load/drop/clear
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             zero_on_clear,
  input  logic             load,
  input  logic             drop,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // clear beats load beats drop; drop leaves the payload in place
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      if (zero_on_clear) data <= WIDTH'(PIPE_NOP);
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register; PIPE_STAGE_SKID_EN adds a skid slot
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH       = PIPE_DEF_WIDTH,
  parameter int BUBBLE_ZERO = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output occ_t             occupancy
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             main_load;
  logic             main_drop;
  logic [WIDTH-1:0] main_load_data;
  logic             in_fire;
  logic             out_fire;
  logic             zero_on_clear;

  assign zero_on_clear = (BUBBLE_ZERO != 0);
  assign in_fire       = in_valid & in_ready;
  assign out_fire      = main_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_load;
  logic             skid_drop;

  // ready depends only on registered skid state, never on out_ready
  assign in_ready       = reset & ~skid_valid;
  assign main_load      = (out_fire & skid_valid) | (in_fire & (~main_valid | out_fire));
  assign main_load_data = skid_valid ? skid_data : in_data;
  assign main_drop      = out_fire & ~main_load;
  assign skid_load      = in_fire & main_valid & ~out_fire;
  assign skid_drop      = out_fire & skid_valid;

  pipe_slot #(.WIDTH(WIDTH)) u_skid (
    .clk          (clk),
    .reset        (reset),
    .clear        (flush),
    .zero_on_clear(zero_on_clear),
    .load         (skid_load),
    .drop         (skid_drop),
    .load_data    (in_data),
    .valid        (skid_valid),
    .data         (skid_data)
  );

  assign occupancy = occ_count(main_valid, skid_valid);
`else
  assign in_ready       = reset & (~main_valid | out_ready);
  assign main_load      = in_fire;
  assign main_load_data = in_data;
  assign main_drop      = out_fire & ~in_fire;
  assign occupancy      = occ_count(main_valid, 1'b0);
`endif

  pipe_slot #(.WIDTH(WIDTH)) u_main (
    .clk          (clk),
    .reset        (reset),
    .clear        (flush),
    .zero_on_clear(zero_on_clear),
    .load         (main_load),
    .drop         (main_drop),
    .load_data    (main_load_data),
    .valid        (main_valid),
    .data         (main_data)
  );

  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized queue-model bench for pipe_stage_reg
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W = 64;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  occ_t         occupancy;

  pipe_stage_reg #(.WIDTH(W), .BUBBLE_ZERO(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] q[$];
  bit           stall_pending = 0;
  logic [W-1:0] stall_data;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // one clock: compare at the falling edge, advance the queue model at the rising edge
  task automatic cycle();
    logic exp_rdy;
    bit   do_in, do_out;
    @(negedge clk);
    exp_rdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready);
    check("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    check("occupancy", {62'd0, occupancy}, W'(q.size()));
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    if (q.size() != 0) check("out_data", out_data, q[0]);
    if (stall_pending) check("stall_hold", out_data, stall_data);
    do_out = (q.size() != 0) && out_ready;
    do_in  = in_valid && exp_rdy;
    stall_pending = (q.size() != 0) && !out_ready && !flush;
    if (q.size() != 0) stall_data = q[0];
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (do_out) void'(q.pop_front());
      if (do_in) q.push_back(in_data);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_occupancy", {62'd0, occupancy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // streaming 1..4 with downstream always ready
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) cycle();

    // back-pressure
    drive(1'b1, 64'hA, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 64'hB, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("skid_occ2", {62'd0, occupancy}, 64'd2);
    check("skid_in_ready0", {63'd0, in_ready}, 64'd0);
    check("skid_hold_A", out_data, 64'hA);
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) cycle();
`else
    #1;
    check("bp_in_ready0", {63'd0, in_ready}, 64'd0);
    cycle();
    out_ready = 1'b1;
    #1;
    check("bp_in_ready1", {63'd0, in_ready}, 64'd1);
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) cycle();
`endif

    // flush with a full stage and a simultaneous push of 0xC
    for (int i = 0; i < CAP; i++) begin
      drive(1'b1, W'(64'h100 + i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 64'hC, 1'b0, 1'b1);
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    check("flush_occ", {62'd0, occupancy}, 64'd0);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_out_data", out_data, 64'd0);
    repeat (2) cycle();

    // asynchronous reset between edges with one entry held
    drive(1'b1, 64'h77, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("areset_out_valid", {63'd0, out_valid}, 64'd0);
    check("areset_out_data", out_data, 64'd0);
    check("areset_occ", {62'd0, occupancy}, 64'd0);
    check("areset_in_ready", {63'd0, in_ready}, 64'd0);
    q.delete();
    stall_pending = 0;
    drive(1'b1, 64'h55, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("areset_hold_ready", {63'd0, in_ready}, 64'd0);
    check("areset_hold_valid", {63'd0, out_valid}, 64'd0);
    #2;
    reset = 1'b1;
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle();

    // random stress
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom(), $urandom()},
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
      cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
